drec_sequencer: RTL

DREC_SEQUENCER -- requirements
Module: drec_sequencer

---
 rtl/drec_pkg.sv | 31 +++
 rtl/drec_tick_gen.sv | 28 ++
 rtl/drec_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/drec_pkg.sv
// Shared encodings and default constants for the digital recorder sequencer.
package drec_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 24;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_SAMPLE_DIV = 25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_RECORD = 2'd2,
        ST_PAUSE  = 2'd3
    } drec_state_e;

    // Frame transfer phases; XF_NONE means the FSM is at a frame boundary.
    typedef enum logic [2:0] {
        XF_NONE,
        XF_CAPTURE,
        XF_WRITE,
        XF_RD_REQ,
        XF_RD_WAIT,
        XF_RD_ACK
    } drec_xfer_e;

    // Largest whole-frame word count that fits in the address space.
    function automatic int full_words(input int addr_w, input int num_ch);
        return ((1 << addr_w) / num_ch) * num_ch;
    endfunction

endpackage

// File: rtl/drec_tick_gen.sv
// Free-running sample-rate divider: one-cycle tick every SAMPLE_DIV clocks.
module drec_tick_gen
    import drec_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/drec_sequencer.sv
// Record/playback sequencer: moves interleaved sample frames between the
// ADC/DAC and an SDRAM word port, one frame per sample tick.
module drec_sequencer
    import drec_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     play_btn,
    input  logic                     rec_btn,
    input  logic                     pause_btn,
    input  logic                     loop_en,
    output logic                     btn_rst,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    output logic                     adc_enable,
    output logic [NUM_CH*DATA_W-1:0] dac_data,
    output logic                     dac_enable,
    output logic [DATA_W-1:0]        sdram_wr_data,
    output logic [ADDR_W-1:0]        sdram_wr_addr,
    output logic                     sdram_wr_enable,
    input  logic                     sdram_wr_ack,
    output logic [ADDR_W-1:0]        sdram_rd_addr,
    output logic                     sdram_rd_enable,
    input  logic [DATA_W-1:0]        sdram_rd_data,
    input  logic                     sdram_rd_data_rdy,
    output logic                     sdram_rd_data_ack,
    output logic [1:0]               state,
    // One bit wider than the address so a completely full memory is representable.
    output logic [ADDR_W:0]          rec_len,
    output logic                     overrun
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW1  = ADDR_W + 1;
    localparam logic [ADDR_W:0]   FULL    = AW1'(full_words(ADDR_W, NUM_CH));
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

    drec_state_e st_q, st_d, mode_q;
    drec_xfer_e  xf_q, xf_d;

    logic                          tick;
    logic [ADDR_W:0]               addr_q, addr_nxt, rec_len_q, len_val;
    logic [CH_W-1:0]               ch_q;
    logic [NUM_CH-1:0][DATA_W-1:0] frame_q;
    logic [NUM_CH*DATA_W-1:0]      dac_q;
    logic                          dac_en_q, btn_rst_q, overrun_q;
    logic                          addr_clr, addr_inc, addr_wrap, len_load;
    logic                          rd_capture, dac_load, ch_clr, ch_inc;
    logic                          last_ch, any_stop;

    drec_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign addr_nxt = addr_q + 1'b1;
    assign last_ch  = (ch_q == LAST_CH);
    assign any_stop = play_btn | rec_btn;

    always_comb begin
        st_d       = st_q;
        xf_d       = xf_q;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        addr_wrap  = 1'b0;
        len_load   = 1'b0;
        len_val    = addr_q;
        rd_capture = 1'b0;
        dac_load   = 1'b0;
        ch_clr     = 1'b0;
        ch_inc     = 1'b0;
        case (xf_q)
            XF_NONE: begin
                // Button latches still read high while btn_rst is clearing them.
                if (!btn_rst_q) begin
                    case (st_q)
                        ST_IDLE: begin
                            if (play_btn && rec_len_q != '0) begin
                                st_d     = ST_PLAY;
                                addr_clr = 1'b1;
                            end else if (rec_btn) begin
                                st_d     = ST_RECORD;
                                addr_clr = 1'b1;
                            end
                        end
                        ST_PLAY, ST_RECORD: begin
                            if (any_stop) begin
                                st_d     = ST_IDLE;
                                len_load = (st_q == ST_RECORD);
                            end else if (pause_btn) begin
                                st_d = ST_PAUSE;
                            end
                        end
                        default: begin
                            if (any_stop) begin
                                st_d     = ST_IDLE;
                                len_load = (mode_q == ST_RECORD);
                            end else if (pause_btn) begin
                                st_d = mode_q;
                            end
                        end
                    endcase
                end
                if (st_d == st_q && tick) begin
                    ch_clr = 1'b1;
                    if (st_q == ST_RECORD)
                        xf_d = XF_CAPTURE;
                    else if (st_q == ST_PLAY)
                        xf_d = XF_RD_REQ;
                end
            end
            XF_CAPTURE: xf_d = XF_WRITE;
            XF_WRITE: begin
                if (sdram_wr_ack) begin
                    addr_inc = 1'b1;
                    if (last_ch) begin
                        xf_d = XF_NONE;
                        if (addr_nxt == FULL) begin
                            st_d     = ST_IDLE;
                            len_load = 1'b1;
                            len_val  = addr_nxt;
                        end
                    end else begin
                        ch_inc = 1'b1;
                    end
                end
            end
            XF_RD_REQ: xf_d = XF_RD_WAIT;
            XF_RD_WAIT: begin
                if (sdram_rd_data_rdy) begin
                    rd_capture = 1'b1;
                    xf_d       = XF_RD_ACK;
                end
            end
            XF_RD_ACK: begin
                if (last_ch) begin
                    dac_load = 1'b1;
                    xf_d     = XF_NONE;
                    if (addr_nxt == rec_len_q && loop_en) begin
                        addr_wrap = 1'b1;
                    end else begin
                        addr_inc = 1'b1;
                        if (addr_nxt == rec_len_q)
                            st_d = ST_IDLE;
                    end
                end else begin
                    addr_inc = 1'b1;
                    ch_inc   = 1'b1;
                    xf_d     = XF_RD_REQ;
                end
            end
            default: xf_d = XF_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= ST_IDLE;
            xf_q      <= XF_NONE;
            mode_q    <= ST_PLAY;
            btn_rst_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            xf_q      <= xf_d;
            btn_rst_q <= (st_d != st_q);
            if (st_d == ST_PAUSE && st_q != ST_PAUSE)
                mode_q <= st_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            ch_q      <= '0;
            frame_q   <= '0;
            dac_q     <= '0;
            dac_en_q  <= 1'b0;
            rec_len_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            dac_en_q <= dac_load;
            if (addr_clr || addr_wrap)
                addr_q <= '0;
            else if (addr_inc)
                addr_q <= addr_nxt;
            if (addr_clr)
                overrun_q <= 1'b0;
            else if (tick && xf_q != XF_NONE)
                overrun_q <= 1'b1;
            if (ch_clr)
                ch_q <= '0;
            else if (ch_inc)
                ch_q <= ch_q + 1'b1;
            // adc_enable is high exactly while XF_CAPTURE is current.
            if (xf_q == XF_CAPTURE)
                frame_q <= adc_data;
            else if (rd_capture)
                frame_q[ch_q] <= sdram_rd_data;
            if (dac_load)
                dac_q <= frame_q;
            if (len_load)
                rec_len_q <= len_val;
        end
    end

    assign state             = st_q;
    assign btn_rst           = btn_rst_q;
    assign adc_enable        = (xf_q == XF_CAPTURE);
    assign sdram_wr_enable   = (xf_q == XF_WRITE);
    assign sdram_wr_data     = frame_q[ch_q];
    assign sdram_wr_addr     = addr_q[ADDR_W-1:0];
    assign sdram_rd_enable   = (xf_q == XF_RD_REQ);
    assign sdram_rd_addr     = addr_q[ADDR_W-1:0];
    assign sdram_rd_data_ack = (xf_q == XF_RD_ACK);
    assign dac_data          = dac_q;
    assign dac_enable        = dac_en_q;
    assign rec_len           = rec_len_q;
    assign overrun           = overrun_q;

endmodule
